lc3_microsequencer: RTL and testbench

Microsequencer for the LC-3 microcoded control unit. It holds the current microstate, computes the next microstate from the active microinstruction's IRD/COND/J fields and datapath status, and drives the control store read address and read enable. It also registers BEN, detects stalled memory waits, and counts decoded instructions.

---
 rtl/lc3_microsequencer.sv | 111 +++++++++++
 tb/tb_lc3_microsequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: holds the current microstate and computes the next one from
// IRD/COND/J. Also keeps BEN, a memory-wait timeout monitor and a decoded-instruction counter.
module lc3_microsequencer #(
  parameter int AddrBusSize = 6,
  parameter int ResetState  = 18,
  parameter int DecodeState = 32,
  parameter int MemTimeout  = 255,
  parameter int CountWidth  = 16
) (
  input  logic                   i_CLK,
  input  logic                   i_RST_N,
  input  logic                   i_run,
  input  logic                   i_IRD,
  input  logic [2:0]             i_COND,
  input  logic [AddrBusSize-1:0] i_J,
  input  logic                   i_LD_BEN,
  input  logic [15:0]            i_IR,
  input  logic                   i_N,
  input  logic                   i_Z,
  input  logic                   i_P,
  input  logic                   i_R,
  input  logic                   i_PSR15,
  input  logic                   i_INT,
  input  logic                   i_ACV,
  output logic [AddrBusSize-1:0] o_state,
  output logic                   o_cs_read_en,
  output logic                   o_BEN,
  output logic                   o_mem_timeout,
  output logic [CountWidth-1:0]  o_instr_count
);

  localparam logic [AddrBusSize-1:0] RstState = AddrBusSize'(ResetState);
  localparam logic [AddrBusSize-1:0] DecState = AddrBusSize'(DecodeState);
  localparam logic [7:0]             TimeoutVal = 8'(MemTimeout);
  localparam bit                     TimeoutOn  = (MemTimeout != 0);

  logic [AddrBusSize-1:0] state_q, state_d, next_state;
  logic                   ben_q, ben_d;
  logic                   timeout_q, timeout_d;
  logic                   en_q, en_d;
  logic [7:0]             wait_q, wait_d, wait_inc;
  logic [CountWidth-1:0]  count_q, count_d;
  logic                   advance, mem_wait, timeout_hit;

  wire unused_ir = ^i_IR[8:0];

  // Next microstate from the active microinstruction fields
  always_comb begin
    next_state = i_J;
    if (i_IRD) begin
      next_state = AddrBusSize'(i_IR[15:12]);
    end else begin
      case (i_COND)
        3'b001:  next_state[1] = i_J[1] | i_R;
        3'b010:  next_state[2] = i_J[2] | ben_q;
        3'b011:  next_state[0] = i_J[0] | i_IR[11];
        3'b100:  next_state[3] = i_J[3] | i_PSR15;
        3'b101:  next_state[4] = i_J[4] | i_INT;
        3'b110:  next_state[5] = i_J[5] | i_ACV;
        default: next_state = i_J;
      endcase
    end
  end

  // A memory wait that reaches the limit freezes the sequencer at the waiting state
  always_comb begin
    advance     = i_run & ~timeout_q;
    mem_wait    = (i_COND == 3'b001) & ~i_IRD & ~i_R;
    wait_inc    = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
    timeout_hit = TimeoutOn & advance & mem_wait & (wait_inc == TimeoutVal);

    state_d   = state_q;
    ben_d     = ben_q;
    wait_d    = wait_q;
    count_d   = count_q;
    timeout_d = timeout_q | timeout_hit;
    en_d      = 1'b1;

    if (advance) begin
      wait_d = mem_wait ? wait_inc : 8'd0;
      if (!timeout_hit) state_d = next_state;
      if (i_LD_BEN) ben_d = (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P);
      if (i_IRD && (state_q == DecState)) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= RstState;
      ben_q     <= 1'b0;
      timeout_q <= 1'b0;
      en_q      <= 1'b0;
      wait_q    <= 8'd0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ben_q     <= ben_d;
      timeout_q <= timeout_d;
      en_q      <= en_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
    end
  end

  assign o_state       = state_q;
  assign o_BEN         = ben_q;
  assign o_mem_timeout = timeout_q;
  assign o_cs_read_en  = en_q & ~timeout_q;
  assign o_instr_count = count_q;

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Directed bench for lc3_microsequencer: next-state rules, BEN, wait timeout, run hold, counter wrap.
module tb_lc3_microsequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, ird, ld_ben, n, z, p, r, psr15, intr, acv;
  logic [2:0]  cond;
  logic [5:0]  j;
  logic [15:0] ir;
  logic [5:0]  state;
  logic        cs_en, ben, tmo;
  logic [15:0] icnt;

  logic        w_run, w_ird;
  logic [15:0] w_ir;
  logic [5:0]  w_state;
  logic        w_cs_en, w_ben, w_tmo;
  logic [15:0] w_icnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lc3_microsequencer #(.MemTimeout(4)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_run(run), .i_IRD(ird), .i_COND(cond), .i_J(j),
    .i_LD_BEN(ld_ben), .i_IR(ir), .i_N(n), .i_Z(z), .i_P(p), .i_R(r), .i_PSR15(psr15),
    .i_INT(intr), .i_ACV(acv), .o_state(state), .o_cs_read_en(cs_en), .o_BEN(ben),
    .o_mem_timeout(tmo), .o_instr_count(icnt)
  );

  // Decode state 0 with opcode 0 loops on itself, giving one decode per cycle.
  lc3_microsequencer #(.DecodeState(0)) u_wrap (
    .i_CLK(clk), .i_RST_N(rst_n), .i_run(w_run), .i_IRD(w_ird), .i_COND(3'b000), .i_J(6'd0),
    .i_LD_BEN(1'b0), .i_IR(w_ir), .i_N(1'b0), .i_Z(1'b0), .i_P(1'b0), .i_R(1'b0),
    .i_PSR15(1'b0), .i_INT(1'b0), .i_ACV(1'b0), .o_state(w_state), .o_cs_read_en(w_cs_en),
    .o_BEN(w_ben), .o_mem_timeout(w_tmo), .o_instr_count(w_icnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fields(input logic i, input logic [2:0] c, input logic [5:0] jj);
    ird = i; cond = c; j = jj;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ird = 1'b0; ld_ben = 1'b0; cond = 3'b000; j = 6'd0; ir = 16'h0;
    n = 1'b0; z = 1'b0; p = 1'b0; r = 1'b0; psr15 = 1'b0; intr = 1'b0; acv = 1'b0;
    w_run = 1'b0; w_ird = 1'b0; w_ir = 16'h0;
    step(); step();
    chk("rst_state", state, 18);
    chk("rst_cs_en", cs_en, 0);
    chk("rst_ben", ben, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_count", icnt, 0);

    // Release reset away from the edge, then fetch 18 -> 33
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; fields(0, 3'b000, 6'd33);
    step();
    chk("fetch_state", state, 33);
    chk("fetch_cs_en", cs_en, 1);

    fields(0, 3'b000, 6'd32); step();
    chk("to_decode", state, 32);
    fields(1, 3'b000, 6'd0); ir = 16'h1234; step();
    chk("ird_1234", state, 1);
    chk("count_1", icnt, 1);
    fields(0, 3'b000, 6'd32); step();
    chk("ird0_nocount", icnt, 1);
    fields(1, 3'b101, 6'd7); ir = 16'hF025; step();
    chk("ird_f025", state, 15);
    chk("count_2", icnt, 2);

    // BEN taken: IR[11:9]=010 with Z
    fields(0, 3'b000, 6'd20); ir = 16'h0400; z = 1'b1; ld_ben = 1'b1; step();
    chk("ben_z", ben, 1);
    chk("ben_ld_state", state, 20);
    ld_ben = 1'b0; fields(0, 3'b010, 6'd0); step();
    chk("br_taken", state, 4);
    // BEN not taken: only N set
    fields(0, 3'b000, 6'd20); z = 1'b0; n = 1'b1; ld_ben = 1'b1; step();
    chk("ben_n_only", ben, 0);
    ld_ben = 1'b0; fields(0, 3'b010, 6'd0); step();
    chk("br_not_taken", state, 0);
    // Same-cycle load and branch uses old BEN
    n = 1'b0; z = 1'b1; ld_ben = 1'b1; fields(0, 3'b010, 6'd0); step();
    chk("br_old_ben", state, 0);
    chk("ben_loaded", ben, 1);
    ld_ben = 1'b0; z = 1'b0;

    // Remaining COND selects
    ir = 16'h0800; fields(0, 3'b011, 6'd0); step(); chk("cond_ir11", state, 1);
    psr15 = 1'b1; fields(0, 3'b100, 6'd0); step(); chk("cond_psr", state, 8);
    intr = 1'b1; fields(0, 3'b101, 6'd0); step(); chk("cond_int", state, 16);
    acv = 1'b1; fields(0, 3'b110, 6'd0); step(); chk("cond_acv", state, 32);
    r = 1'b1; fields(0, 3'b111, 6'd5); step(); chk("cond_rsvd", state, 5);
    fields(0, 3'b000, 6'd0); step(); chk("cond_none", state, 0);
    psr15 = 1'b0; intr = 1'b0; acv = 1'b0; r = 1'b0; ir = 16'h0;

    // Memory wait: 3 not-ready cycles, R wins on the edge that would time out
    fields(0, 3'b000, 6'd33); step();
    fields(0, 3'b001, 6'd33);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wait_hold", state, 33);
    end
    r = 1'b1; step();
    chk("wait_ready", state, 35);
    chk("wait_no_tmo", tmo, 0);

    // Run=0 holds everything, including the wait counter
    r = 1'b0; fields(0, 3'b000, 6'd33); step();
    fields(0, 3'b001, 6'd33); step(); step();
    run = 1'b0; ld_ben = 1'b1; n = 1'b1; ir = 16'h0800; fields(1, 3'b000, 6'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_state", state, 33);
    end
    chk("hold_ben", ben, 1);
    chk("hold_count", icnt, 2);
    run = 1'b1; ld_ben = 1'b0; n = 1'b0; fields(0, 3'b001, 6'd33); step();
    chk("wait3_no_tmo", tmo, 0);
    step();
    chk("tmo_set", tmo, 1);
    chk("tmo_state", state, 33);
    chk("tmo_cs_en", cs_en, 0);
    r = 1'b1; fields(0, 3'b000, 6'd10); step(); step();
    chk("tmo_sticky", tmo, 1);
    chk("tmo_frozen", state, 33);

    // Asynchronous reset clears all mid-cycle
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("arst_state", state, 18);
    chk("arst_tmo", tmo, 0);
    chk("arst_cs_en", cs_en, 0);
    chk("arst_count", icnt, 0);
    chk("arst_ben", ben, 0);
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; r = 1'b0;

    // Counter wrap: 65536 decodes
    w_run = 1'b1; w_ird = 1'b0; step();
    chk("wrap_start", w_state, 0);
    w_ird = 1'b1; w_ir = 16'h0000;
    repeat (65535) step();
    chk("wrap_ffff", w_icnt, 16'hFFFF);
    step();
    chk("wrap_zero", w_icnt, 0);
    chk("wrap_state", w_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
